// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: bundle of the core request/response handshake and the
// data-RAM port of mem_access_unit.
//   req_*   : core request (valid/ready, we, size, signed, addr, wdata)
//   resp_*  : one-cycle completion pulse with load data and misalignment flag
//   *_mem   : RAM enable, word address, byte-lane write enables/data, read data
// Modports: slave = the access unit itself, master = core + RAM environment.

interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic        en_mem;
   logic [31:0] addr_mem;
   logic [3:0]  w_en_mem;
   logic [31:0] w_data_mem;
   logic [31:0] r_data_mem;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, r_data_mem,
      output req_ready, resp_valid, resp_rdata, resp_err,
             en_mem, addr_mem, w_en_mem, w_data_mem
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, r_data_mem,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             en_mem, addr_mem, w_en_mem, w_data_mem
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit between a core request
// port and a synchronous (1-cycle read latency) data RAM. Stores drive
// little-endian byte lanes with replicated data; loads select the byte/half
// from the returned word and sign- or zero-extend it.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mem_access_unit_if.slave (req_*, resp_*, en/addr/w_en/w_data/r_data _mem)
// Build option MEM_ACCESS_MISALIGN_TRAP_EN: misaligned half/word requests skip
// the RAM and complete next cycle with resp_err=1. Without it resp_err is tied
// low and low address bits below the access size are ignored.

module mem_access_unit (
   input  logic             clk,
   input  logic             rst,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state;
   state_t      next_state;

   logic        we_q;
   logic        signed_q;
   logic [1:0]  size_q;
   logic [1:0]  addr_lo_q;

   logic        handshake;
   logic        misaligned;
   logic [3:0]  st_lanes;
   logic [31:0] st_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign bus.req_ready = (state == IDLE) && !rst;
   assign handshake     = bus.req_valid && bus.req_ready;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   always_comb begin
      misaligned = 1'b0;
      case (bus.req_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = bus.req_addr[0];
         default: misaligned = |bus.req_addr[1:0];
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic; a trapped request bypasses the RAM entirely
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (handshake) next_state = misaligned ? RESP : ISSUE;
         ISSUE:   next_state = we_q ? RESP : WAIT;
         WAIT:    next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Store lane enables and replicated data, from the live request
   always_comb begin
      st_lanes = 4'b1111;
      st_data  = bus.req_wdata;
      case (bus.req_size)
         2'd0: begin
            st_lanes = 4'b0001 << bus.req_addr[1:0];
            st_data  = {4{bus.req_wdata[7:0]}};
         end
         2'd1: begin
            st_lanes = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            st_data  = {2{bus.req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load lane select and extension, from the captured request
   always_comb begin
      ld_byte = bus.r_data_mem[7:0];
      case (addr_lo_q)
         2'd0: ld_byte = bus.r_data_mem[7:0];
         2'd1: ld_byte = bus.r_data_mem[15:8];
         2'd2: ld_byte = bus.r_data_mem[23:16];
         2'd3: ld_byte = bus.r_data_mem[31:24];
         default: ;
      endcase
      ld_half = addr_lo_q[1] ? bus.r_data_mem[31:16] : bus.r_data_mem[15:0];
      ld_data = bus.r_data_mem;
      case (size_q)
         2'd0: ld_data = signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
         2'd1: ld_data = signed_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
         default: ;
      endcase
   end

   // Request capture, memory-side outputs and response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q           <= 1'b0;
         signed_q       <= 1'b0;
         size_q         <= '0;
         addr_lo_q      <= '0;
         bus.en_mem     <= 1'b0;
         bus.addr_mem   <= '0;
         bus.w_en_mem   <= '0;
         bus.w_data_mem <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
      end else begin
         bus.en_mem     <= 1'b0;
         bus.w_en_mem   <= '0;
         bus.resp_valid <= (next_state == RESP);
         if (handshake) begin
            we_q      <= bus.req_we;
            signed_q  <= bus.req_signed;
            size_q    <= bus.req_size;
            addr_lo_q <= bus.req_addr[1:0];
         end
         if (handshake && (next_state == ISSUE)) begin
            bus.en_mem     <= 1'b1;
            bus.addr_mem   <= {bus.req_addr[31:2], 2'b00};
            bus.w_en_mem   <= bus.req_we ? st_lanes : 4'b0000;
            bus.w_data_mem <= st_data;
         end
         if (state == WAIT) bus.resp_rdata <= ld_data;
      end
   end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   // Error flag rides alongside the trap completion pulse only
   always_ff @(posedge clk or posedge rst) begin
      if (rst) bus.resp_err <= 1'b0;
      else     bus.resp_err <= handshake && misaligned;
   end
`else
   assign bus.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized load/store traffic against a
// byte-addressed reference memory; a behavioural 1-cycle RAM serves the DUT.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to build the trap variant.

module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] last_rdata;          // value resp_rdata must currently hold
   logic [7:0]  ref_mem [0:1023];    // reference byte memory (addresses mod 1024)
   logic [31:0] ram [0:255];         // RAM served to the DUT
   logic        ram_loaded = 1'b0;
   logic [31:0] obs;

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int unsigned i);
      return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
         ram_loaded <= 1'b1;
      end else if (bus.en_mem) begin
         bus.r_data_mem <= ram[bus.addr_mem[9:2]];
         for (int i = 0; i < 4; i++)
            if (bus.w_en_mem[i]) ram[bus.addr_mem[9:2]][8*i +: 8] <= bus.w_data_mem[8*i +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic scramble();
      bus.req_valid  = 1'($urandom_range(1, 0));
      bus.req_we     = 1'($urandom);
      bus.req_size   = 2'($urandom);
      bus.req_signed = 1'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
   endtask

   // One complete request; checks every cycle from handshake to return to IDLE.
   task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata_obs);
      int unsigned nbytes;
      logic        misal;
      logic [31:0] eff, base, a_i, exp_wd, exp_ld;
      logic [3:0]  exp_wen;

      nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      misal  = (addr % nbytes) != 0;
      eff    = addr - (addr % nbytes);
      base   = eff & ~32'h3;
      exp_wen = '0;
      exp_wd  = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         a_i = base + i;
         if (we && a_i >= eff && a_i < eff + nbytes) exp_wen[i] = 1'b1;
         exp_wd[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
      end

      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      #1;
      check("ready_idle", 32'(bus.req_ready), 32'd1);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      if (misal) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         #1;
         check("trap_en_mem", 32'(bus.en_mem), 32'd0);
         check("trap_resp_valid", 32'(bus.resp_valid), 32'd1);
         check("trap_resp_err", 32'(bus.resp_err), 32'd1);
         check("trap_rdata_hold", bus.resp_rdata, last_rdata);
         rdata_obs = bus.resp_rdata;
         @(negedge clk);
         #1;
         check("trap_after_valid", 32'(bus.resp_valid), 32'd0);
         check("trap_after_ready", 32'(bus.req_ready), 32'd1);
         return;
      end
`else
      if (misal) eff = eff; // low bits simply ignored in this build
`endif

      @(negedge clk);                      // T+1: ISSUE
      scramble();
      #1;
      check("issue_en_mem", 32'(bus.en_mem), 32'd1);
      check("issue_addr_mem", bus.addr_mem, base);
      check("issue_w_en_mem", 32'(bus.w_en_mem), 32'(exp_wen));
      if (we) check("issue_w_data_mem", bus.w_data_mem, exp_wd);
      check("issue_ready", 32'(bus.req_ready), 32'd0);
      check("issue_resp_valid", 32'(bus.resp_valid), 32'd0);

      if (we) begin
         @(negedge clk);                   // T+2: RESP
         bus.req_valid = 1'b0;
         #1;
         check("st_resp_valid", 32'(bus.resp_valid), 32'd1);
         check("st_resp_err", 32'(bus.resp_err), 32'd0);
         check("st_rdata_hold", bus.resp_rdata, last_rdata);
         check("st_en_mem_off", 32'(bus.en_mem), 32'd0);
         for (int unsigned k = 0; k < nbytes; k++) ref_mem[(eff + k) & 32'h3FF] = wdata[8*k +: 8];
      end else begin
         @(negedge clk);                   // T+2: WAIT
         scramble();
         #1;
         check("ld_wait_valid", 32'(bus.resp_valid), 32'd0);
         check("ld_wait_en_mem", 32'(bus.en_mem), 32'd0);
         check("ld_wait_ready", 32'(bus.req_ready), 32'd0);
         exp_ld = '0;
         for (int unsigned k = 0; k < nbytes; k++) exp_ld[8*k +: 8] = ref_mem[(eff + k) & 32'h3FF];
         if (sgn && nbytes < 4 && exp_ld[8*nbytes-1])
            for (int unsigned k = nbytes; k < 4; k++) exp_ld[8*k +: 8] = 8'hFF;
         @(negedge clk);                   // T+3: RESP
         bus.req_valid = 1'b0;
         #1;
         check("ld_resp_valid", 32'(bus.resp_valid), 32'd1);
         check("ld_resp_err", 32'(bus.resp_err), 32'd0);
         check("ld_rdata", bus.resp_rdata, exp_ld);
         last_rdata = exp_ld;
      end
      rdata_obs = bus.resp_rdata;
      @(negedge clk);
      #1;
      check("after_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("after_ready", 32'(bus.req_ready), 32'd1);
   endtask

   task automatic reset_in_wait();
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd2;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h10;
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      check("rw_issue_en", 32'(bus.en_mem), 32'd1);
      @(negedge clk);                      // WAIT
      rst = 1'b1;
      #1;
      check("rw_en_mem", 32'(bus.en_mem), 32'd0);
      check("rw_w_en_mem", 32'(bus.w_en_mem), 32'd0);
      check("rw_addr_mem", bus.addr_mem, 32'd0);
      check("rw_w_data_mem", bus.w_data_mem, 32'd0);
      check("rw_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rw_resp_rdata", bus.resp_rdata, 32'd0);
      check("rw_resp_err", 32'(bus.resp_err), 32'd0);
      check("rw_ready_in_rst", 32'(bus.req_ready), 32'd0);
      last_rdata = '0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rw_ready_after", 32'(bus.req_ready), 32'd1);
      check("rw_no_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      #1;
      check("rw_no_resp2", 32'(bus.resp_valid), 32'd0);
      check("rw_en_idle", 32'(bus.en_mem), 32'd0);
   endtask

   // Loads with req_valid held: one handshake every 4 cycles.
   task automatic back_to_back();
      logic [31:0] exp;
      exp = '0;
      for (int unsigned k = 0; k < 4; k++) exp[8*k +: 8] = ref_mem[32'h40 + k];
      @(negedge clk);
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd2;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h40;
      for (int unsigned cyc = 0; cyc <= 12; cyc++) begin
         if (cyc != 0) @(negedge clk);
         bus.req_valid = (cyc != 12);
         bus.req_wdata = $urandom;
         #1;
         check("b2b_ready", 32'(bus.req_ready), 32'(cyc % 4 == 0));
         check("b2b_en_mem", 32'(bus.en_mem), 32'(cyc % 4 == 1));
         check("b2b_resp_valid", 32'(bus.resp_valid), 32'(cyc % 4 == 3));
         if (cyc % 4 == 3) check("b2b_rdata", bus.resp_rdata, exp);
      end
      last_rdata = exp;
   endtask

   initial begin
      logic [31:0] w;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = '0;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      rst            = 1'b1;
      last_rdata     = '0;
      for (int unsigned i = 0; i < 256; i++) begin
         w = init_word(i);
         for (int unsigned b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
      end

      #1;
      check("rst_en_mem", 32'(bus.en_mem), 32'd0);
      check("rst_w_en_mem", 32'(bus.w_en_mem), 32'd0);
      check("rst_addr_mem", bus.addr_mem, 32'd0);
      check("rst_w_data_mem", bus.w_data_mem, 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_resp_err", 32'(bus.resp_err), 32'd0);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(bus.req_ready), 32'd1);

      do_access(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, obs);
      do_access(1'b1, 2'd2, 1'b0, 32'h200, 32'h80F17F02, obs);
      do_access(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, obs);
      check("lb_signed_0x203", obs, 32'hFFFFFF80);
      do_access(1'b0, 2'd1, 1'b0, 32'h200, 32'h0, obs);
      check("lhu_0x200", obs, 32'h00007F02);
      do_access(1'b1, 2'd1, 1'b0, 32'h2, 32'h00001234, obs);
      do_access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, obs);
      check("lw_0x0_hi_half", {16'h0, obs[31:16]}, 32'h00001234);
      do_access(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, obs);
      do_access(1'b0, 2'd1, 1'b1, 32'h201, 32'h0, obs);

      reset_in_wait();
      back_to_back();

      for (int unsigned n = 0; n < 150; n++)
         do_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, obs);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
